// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 job arbiter: FSM state codes, block width
// and the standard SM4 reference vector.
package sm4_pkg;

  localparam int SM4_BLK_W = 128;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] CLR   = 3'd2;
  localparam logic [2:0] RUN   = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = IDLE,
    S_GRANT = GRANT,
    S_CLR   = CLR,
    S_RUN   = RUN,
    S_RESP  = RESP
  } state_e;

  localparam logic [SM4_BLK_W-1:0] KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [SM4_BLK_W-1:0] PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [SM4_BLK_W-1:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

endpackage

// File: rtl/sm4_job_arbiter_if.sv
// Job-port, response-port and core-port bundle of the SM4 job arbiter.
// slave = arbiter view; master = requesters, response consumer and core.
interface sm4_job_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]     REQ_VALID;
  logic [NREQ-1:0]     REQ_READY;
  logic [NREQ*128-1:0] REQ_DATA;
  logic [NREQ*128-1:0] REQ_KEY;
  logic                RSP_VALID;
  logic                RSP_READY;
  logic [127:0]        RSP_DATA;
  logic [IDW-1:0]      RSP_ID;
  logic                RSP_ERR;
  logic                BUSY;
  logic                CORE_RST_N;
  logic                CORE_EN;
  logic [127:0]        CORE_IN_DATA;
  logic [127:0]        CORE_IN_KEY;
  logic [127:0]        CORE_OUT_DATA;
  logic                CORE_OUT_READY;

  modport slave (
    input  REQ_VALID, REQ_DATA, REQ_KEY, RSP_READY, CORE_OUT_DATA, CORE_OUT_READY,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, BUSY,
           CORE_RST_N, CORE_EN, CORE_IN_DATA, CORE_IN_KEY
  );

  modport master (
    output REQ_VALID, REQ_DATA, REQ_KEY, RSP_READY, CORE_OUT_DATA, CORE_OUT_READY,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ID, RSP_ERR, BUSY,
           CORE_RST_N, CORE_EN, CORE_IN_DATA, CORE_IN_KEY
  );
endinterface

// File: rtl/sm4_rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr_i,
// wrapping modulo NREQ, so the last winner has lowest priority.
module sm4_rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic           found;
  logic [IDW-1:0] pos;

  // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      pos = IDW'((int'(ptr_i) + k) % NREQ);
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = pos;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/sm4_job_arbiter.sv
// Shares one SM4 core between NREQ requesters: round-robin grant, pulsed core
// reset, bounded wait for the core, then an ID-tagged response.
module sm4_job_arbiter
  import sm4_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int IDW        = 2,
  parameter int CLR_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input logic               CLK,
  input logic               RST_N,
  sm4_job_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(TIMEOUT + CLR_CYCLES + 1);

  state_e                 state_q, state_d;
  logic [NREQ-1:0]        gnt_q, gnt_d;
  logic [IDW-1:0]         win_q, win_d;
  logic [IDW-1:0]         ptr_q, ptr_d;
  logic [IDW-1:0]         rsp_id_q, rsp_id_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SM4_BLK_W-1:0]   in_data_q, in_data_d;
  logic [SM4_BLK_W-1:0]   in_key_q, in_key_d;
  logic [SM4_BLK_W-1:0]   rsp_data_q, rsp_data_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_err_q, rsp_err_d;
  logic                   core_rst_n_q, core_rst_n_d;
  logic                   core_en_q, core_en_d;

  logic [NREQ-1:0]        pick_gnt;
  logic [IDW-1:0]         pick_idx;
  logic                   pick_any;
  logic [SM4_BLK_W-1:0]   sel_data, sel_key;

  // The pick is registered in IDLE and presented in GRANT, so REQ_READY never
  // depends combinationally on REQ_VALID.
  sm4_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .req_i (bus.REQ_VALID),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win_q == IDW'(k)) begin
        sel_data = bus.REQ_DATA[k*SM4_BLK_W +: SM4_BLK_W];
        sel_key  = bus.REQ_KEY[k*SM4_BLK_W +: SM4_BLK_W];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = '0;
    win_d       = win_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    in_data_d   = in_data_q;
    in_key_d    = in_key_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          win_d   = pick_idx;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        // Winner may have withdrawn since the pick; then nothing is taken.
        if (|(bus.REQ_VALID & gnt_q)) begin
          in_data_d = sel_data;
          in_key_d  = sel_key;
          ptr_d     = win_q;
          cnt_d     = CNT_W'(CLR_CYCLES - 1);
          state_d   = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR: begin
        if (cnt_q == '0) begin
          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        if (bus.CORE_OUT_READY) begin
          rsp_data_d  = bus.CORE_OUT_DATA;
          rsp_err_d   = 1'b0;
          rsp_id_d    = ptr_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          rsp_data_d  = '0;
          rsp_err_d   = 1'b1;
          rsp_id_d    = ptr_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.RSP_READY) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Core controls follow the next state so they come straight from flops.
    core_rst_n_d = (state_d == S_RUN);
    core_en_d    = (state_d == S_CLR) || (state_d == S_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      gnt_q        <= '0;
      win_q        <= '0;
      ptr_q        <= IDW'(NREQ - 1);
      cnt_q        <= '0;
      in_data_q    <= '0;
      in_key_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_err_q    <= 1'b0;
      core_rst_n_q <= 1'b0;
      core_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      win_q        <= win_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      in_data_q    <= in_data_d;
      in_key_q     <= in_key_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      core_rst_n_q <= core_rst_n_d;
      core_en_q    <= core_en_d;
    end
  end

  assign bus.REQ_READY    = gnt_q;
  assign bus.RSP_VALID    = rsp_valid_q;
  assign bus.RSP_DATA     = rsp_data_q;
  assign bus.RSP_ID       = rsp_id_q;
  assign bus.RSP_ERR      = rsp_err_q;
  assign bus.BUSY         = (state_q != S_IDLE);
  assign bus.CORE_RST_N   = core_rst_n_q;
  assign bus.CORE_EN      = core_en_q;
  assign bus.CORE_IN_DATA = in_data_q;
  assign bus.CORE_IN_KEY  = in_key_q;

endmodule

// File: tb/tb_sm4_job_arbiter.sv
// Directed bench for sm4_job_arbiter with a behavioural core stub and a
// job-level scoreboard checked every cycle.
module tb_sm4_job_arbiter;
  import sm4_pkg::*;

  localparam int NREQ       = 4;
  localparam int IDW        = 2;
  localparam int CLR_CYCLES = 2;
  localparam int TIMEOUT    = 64;
  localparam int STUB_LAT   = 35;
  localparam logic [127:0] FILL = {16{8'h5a}};

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sm4_job_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) b();

  sm4_job_arbiter #(
    .NREQ(NREQ), .IDW(IDW), .CLR_CYCLES(CLR_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (b)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in for the real core: the standard vector maps to its known
  // ciphertext, anything else to a simple keyed scramble.
  function automatic logic [127:0] core_fn(input logic [127:0] key, input logic [127:0] pt);
    if (key == KEY && pt == PT) return CT;
    return pt ^ {key[63:0], key[127:64]} ^ FILL;
  endfunction

  // Core stub: ready STUB_LAT enabled cycles after its reset releases.
  logic         stub_on   = 1'b1;
  logic         core_rdy  = 1'b0;
  logic [127:0] core_out  = '0;
  int           s_cnt     = 0;
  assign b.CORE_OUT_READY = core_rdy;
  assign b.CORE_OUT_DATA  = core_out;

  always @(posedge clk or negedge b.CORE_RST_N) begin
    if (!b.CORE_RST_N) begin
      s_cnt    <= 0;
      core_rdy <= 1'b0;
    end else if (b.CORE_EN && stub_on && !core_rdy) begin
      if (s_cnt == STUB_LAT - 1) begin
        core_rdy <= 1'b1;
        core_out <= core_fn(b.CORE_IN_KEY, b.CORE_IN_DATA);
      end else begin
        s_cnt <= s_cnt + 1;
      end
    end
  end

  // ---------------- job-level model and per-cycle compare ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [127:0]   data;
    logic           err;
  } exp_t;

  exp_t         exp_q[$];
  int           last_id  = NREQ - 1;
  bit           busy_job = 1'b0;
  bit           prev_valid = 1'b0;
  int           clr_cnt, run_cnt, first_rdy;
  logic [127:0] exp_pt, exp_key;

  function automatic int rr_expect(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NREQ-1:0] g);
    for (int k = 0; k < NREQ; k++) if (g[k]) return k;
    return -1;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      busy_job   = 1'b0;
      last_id    = NREQ - 1;
      prev_valid = 1'b0;
    end else begin
      if (busy_job && !b.RSP_VALID) begin
        if (!b.CORE_RST_N && b.CORE_EN) clr_cnt++;
        if (b.CORE_RST_N) begin
          run_cnt++;
          if (b.CORE_OUT_READY && first_rdy < 0) first_rdy = run_cnt;
        end
        if (b.CORE_EN) begin
          check("core_in_data", b.CORE_IN_DATA, exp_pt);
          check("core_in_key", b.CORE_IN_KEY, exp_key);
        end
      end
      if (b.REQ_READY != '0) begin
        int g;
        check("rdy_onehot", $countones(b.REQ_READY), 1);
        check("rdy_while_busy", busy_job, 0);
        g = onehot_idx(b.REQ_READY);
        if (b.REQ_VALID[g]) begin
          exp_t e;
          check("rr_order", g, rr_expect(b.REQ_VALID, last_id));
          last_id = g;
          exp_pt  = b.REQ_DATA[g*128 +: 128];
          exp_key = b.REQ_KEY[g*128 +: 128];
          e.id    = IDW'(g);
          e.data  = stub_on ? core_fn(exp_key, exp_pt) : '0;
          e.err   = !stub_on;
          exp_q.push_back(e);
          busy_job  = 1'b1;
          clr_cnt   = 0;
          run_cnt   = 0;
          first_rdy = -1;
        end
      end
      if (b.RSP_VALID) begin
        check("rsp_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          if (!prev_valid) begin
            check("clr_len", clr_cnt, CLR_CYCLES);
            check("run_len", run_cnt, exp_q[0].err ? TIMEOUT : first_rdy);
          end
          check("rsp_data", b.RSP_DATA, exp_q[0].data);
          check("rsp_id", b.RSP_ID, exp_q[0].id);
          check("rsp_err", b.RSP_ERR, exp_q[0].err);
          check("core_parked", {b.CORE_EN, b.CORE_RST_N}, 2'b00);
          if (b.RSP_READY) begin
            void'(exp_q.pop_front());
            busy_job = 1'b0;
          end
        end
      end
      if (busy_job || b.RSP_VALID) check("busy", b.BUSY, 1);
      prev_valid = b.RSP_VALID;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [127:0] key, input logic [127:0] pt);
    b.REQ_VALID[i]          = v;
    b.REQ_DATA[i*128 +: 128] = pt;
    b.REQ_KEY[i*128 +: 128]  = key;
  endtask

  task automatic wait_grant(input int i);
    int cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(b.REQ_READY[i] && b.REQ_VALID[i]) && cyc < 300);
    if (!b.REQ_READY[i]) check("grant_timeout", b.REQ_READY[i], 1);
  endtask

  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!b.RSP_VALID && cyc < 300);
    if (!b.RSP_VALID) check("rsp_timeout", b.RSP_VALID, 1);
  endtask

  // Raise one request, drop it after its grant, return the response fields.
  task automatic do_job(input int i, input logic [127:0] key, input logic [127:0] pt,
                        output logic [127:0] d, output logic [IDW-1:0] id,
                        output logic err, output int lat);
    set_req(i, 1'b1, key, pt);
    wait_grant(i);
    tick();
    b.REQ_VALID[i] = 1'b0;
    wait_rsp(lat);
    d   = b.RSP_DATA;
    id  = b.RSP_ID;
    err = b.RSP_ERR;
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, b.REQ_READY, 0);
    check({tag, "_rsp_valid"}, b.RSP_VALID, 0);
    check({tag, "_rsp_data"}, b.RSP_DATA, 0);
    check({tag, "_rsp_id"}, b.RSP_ID, 0);
    check({tag, "_rsp_err"}, b.RSP_ERR, 0);
    check({tag, "_busy"}, b.BUSY, 0);
    check({tag, "_core_rst_n"}, b.CORE_RST_N, 0);
    check({tag, "_core_en"}, b.CORE_EN, 0);
    check({tag, "_core_in_data"}, b.CORE_IN_DATA, 0);
    check({tag, "_core_in_key"}, b.CORE_IN_KEY, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [127:0]   d, snap_d;
    logic [IDW-1:0] id, snap_id;
    logic           err;
    int             lat;
    bit             stable, seen;

    b.REQ_VALID = '0;
    b.REQ_DATA  = '0;
    b.REQ_KEY   = '0;
    b.RSP_READY = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    tick();
    rst_n = 1'b1;

    // All four requesters held: strict rotation from requester 0.
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 128'(i + 1), 128'(16 * i));
    for (int n = 0; n < 8; n++) begin
      wait_rsp(lat);
      check("rr_seq_id", b.RSP_ID, n % NREQ);
      tick();
    end
    b.REQ_VALID = '0;
    repeat (3) tick();

    // Standard vector from requester 0, with grant-to-response latency.
    do_job(0, KEY, PT, d, id, err, lat);
    check("vec_data", d, 128'h681edf34d206965e86b3e94f536e4246);
    check("vec_id", id, 0);
    check("vec_err", err, 0);
    check("vec_latency", lat, 39);

    // Back-to-back jobs from requester 2; the second must not echo the first.
    do_job(2, KEY, PT, d, id, err, lat);
    check("b2b1_data", d, CT);
    check("b2b1_id", id, 2);
    do_job(2, '0, '0, d, id, err, lat);
    check("b2b2_data", d, FILL);
    check("b2b2_id", id, 2);
    check("b2b2_not_stale", d == CT, 0);

    // Response back-pressure with another requester waiting.
    b.RSP_READY = 1'b0;
    set_req(1, 1'b1, '0, '0);
    set_req(3, 1'b1, KEY, PT);
    wait_grant(3);
    tick();
    b.REQ_VALID[3] = 1'b0;
    wait_rsp(lat);
    snap_d  = b.RSP_DATA;
    snap_id = b.RSP_ID;
    check("hold_first_data", snap_d, CT);
    check("hold_first_id", snap_id, 3);
    stable = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!b.RSP_VALID || b.RSP_DATA !== snap_d || b.RSP_ID !== snap_id || b.REQ_READY != '0)
        stable = 1'b0;
    end
    check("hold_stable", stable, 1);
    tick();
    b.RSP_READY = 1'b1;
    wait_grant(1);
    tick();
    b.REQ_VALID[1] = 1'b0;
    wait_rsp(lat);
    check("after_hold_id", b.RSP_ID, 1);
    check("after_hold_data", b.RSP_DATA, FILL);
    tick();

    // Core never answers: error response after the timeout, then recovery.
    stub_on = 1'b0;
    do_job(0, KEY, PT, d, id, err, lat);
    check("tmo_err", err, 1);
    check("tmo_data", d, 0);
    check("tmo_id", id, 0);
    check("tmo_latency", lat, 1 + CLR_CYCLES + TIMEOUT);
    stub_on = 1'b1;
    do_job(1, KEY, PT, d, id, err, lat);
    check("post_tmo_data", d, CT);
    check("post_tmo_err", err, 0);

    // Reset pulse while the core is running aborts the job.
    set_req(2, 1'b1, KEY, PT);
    wait_grant(2);
    tick();
    b.REQ_VALID[2] = 1'b0;
    for (int n = 0; n < 50 && !b.CORE_RST_N; n++) @(negedge clk);
    check("reached_run", b.CORE_RST_N, 1);
    repeat (5) @(negedge clk);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("abort");
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (b.RSP_VALID) seen = 1'b1;
    end
    check("abort_no_rsp", seen, 0);
    do_job(0, KEY, PT, d, id, err, lat);
    check("post_abort_data", d, CT);
    check("post_abort_id", id, 0);
    check("post_abort_err", err, 0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
